multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: leave IDLE and begin fetching.
REQ-005 The block SHALL have port haltReq, input, 1 bit: stop after the current instruction retires.
REQ-006 The block SHALL have port ins, input, 32 bits: the instruction word from the fetch stage, stable while PC is unchanged.
REQ-007 The block SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-008 The block SHALL have port memAck, input, 1 bit: data-memory access complete.
REQ-009 The block SHALL have ports PCWrite and IRWrite, outputs, 1 bit each: PC-register enable and instruction-latch enable.
REQ-010 The block SHALL have port PCSel, output, 2 bits: next-PC source, 00 = PCp4, 01 = branch target, 10 = jal target.
REQ-011 The block SHALL have ports RegWrite, ALUSrc, MemRead, MemWrite and MemToReg, outputs, 1 bit each: datapath controls (ALUSrc 0 = rs2, 1 = imm).
REQ-012 The block SHALL have port op, output, 3 bits: ALU op, 000 = and, 001 = or, 010 = add, 110 = sub, 011 = slt.
REQ-013 The block SHALL have port state, output, 3 bits: the current FSM state.
REQ-014 The block SHALL have ports busy and illegal, outputs, 1 bit each.
REQ-015 The block SHALL have port retired, output, CNT_W bits: count of retired instructions.

Function
REQ-016 The FSM SHALL have states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to HALT with illegal=1.
REQ-017 The FSM SHALL go from IDLE to FETCH on start=1 and stay in IDLE otherwise; busy SHALL be 1 in states 1-5 only.
REQ-018 In FETCH the block SHALL assert IRWrite=1 for exactly one cycle, then go to DECODE.
REQ-019 In DECODE the block SHALL latch opcode ins[6:0], funct3 ins[14:12] and funct7 bit ins[30] into internal registers; all later controls SHALL use these latched fields.
REQ-020 Legal opcodes SHALL be 0x33 (R), 0x13 (addi), 0x03 (lw), 0x23 (sw), 0x63 (beq) and 0x6F (jal); any other opcode SHALL move DECODE to HALT with illegal=1.
REQ-021 R-type ALU op SHALL be: funct3 000 -> add, or sub if ins[30]=1; 110 -> or; 111 -> and; 010 -> slt; any other funct3 SHALL be illegal.
REQ-022 EXEC for R-type and addi SHALL drive ALUSrc=0 and ALUSrc=1 respectively, then go to WB.
REQ-023 EXEC for lw and sw SHALL drive ALUSrc=1 and op=add, then go to MEM.
REQ-024 EXEC for beq SHALL drive ALUSrc=0, op=sub, PCWrite=1, PCSel=01 if zero=1 and 00 otherwise; the instruction then retires.
REQ-025 EXEC for jal SHALL drive PCWrite=1 and PCSel=10; the instruction then retires; RegWrite SHALL stay 0.
REQ-026 ALU controls SHALL be held in MEM and WB.
REQ-027 In MEM the block SHALL hold MemRead=1 (lw) or MemWrite=1 (sw) until the cycle memAck=1, with no timeout.
REQ-028 On that memAck cycle, lw SHALL go to WB.
REQ-029 On that memAck cycle, sw SHALL assert PCWrite=1, PCSel=00 and retire.
REQ-030 In WB the block SHALL assert RegWrite=1, MemToReg=1 for lw and 0 otherwise, PCWrite=1 and PCSel=00, and retire.
REQ-031 A retire cycle is any cycle with PCWrite=1; PCWrite SHALL be 1 in exactly one cycle per instruction.
REQ-032 On a retire cycle, retired SHALL increment by 1 and wrap from all-ones to 0.
REQ-033 On a retire cycle, the next state SHALL be IDLE if haltReq=1 and FETCH otherwise; haltReq SHALL be ignored in all other cycles.
REQ-034 HALT SHALL be exited only by reset.
REQ-035 Outside the states listed above, every control output SHALL be 0 and op SHALL be 010.
REQ-036 memAck outside MEM SHALL be ignored.

Reset
REQ-037 rst_n=0 SHALL immediately force state=IDLE, all controls 0, op=010, PCSel=00, illegal=0, retired=0 and all latched fields 0, including mid-instruction (for example during MEM with MemWrite=1).
REQ-038 The first rising edge of clk after rst_n deasserts SHALL evaluate from IDLE.

Verification
REQ-039 Scenario: reset, start=1, ins=0x002081B3 (add x3,x1,x2) -> states 1,2,3,5,1; RegWrite=1 only in WB; op=010; retired=1.
REQ-040 Scenario: ins=0x0000A183 (lw), memAck held 0 for 3 cycles then 1 -> MemRead=1 for 4 cycles, then WB with MemToReg=1; 5+3 cycles total.
REQ-041 Scenario: beq with zero=1 -> PCSel=01; with zero=0 -> PCSel=00; each PCWrite=1 in EXEC, and RegWrite never 1.
REQ-042 Scenario: ins=0x0000007F -> DECODE goes to HALT with illegal=1; start and memAck are then ignored until rst_n=0.
REQ-043 Scenario: retired preset to 0xFFFF by running 65535 instructions, plus one more retire -> retired=0x0000; with haltReq=1 at that retire, next state is IDLE.
REQ-044 Scenario: rst_n pulled low mid-MEM for sw -> MemWrite drops to 0 asynchronously, state=0, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback for a
// small RISC-V subset and counts retired instructions.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             haltReq,
  input  logic [31:0]      ins,
  input  logic             zero,
  input  logic             memAck,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic [1:0]       PCSel,
  output logic             RegWrite,
  output logic             ALUSrc,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic [2:0]       op,
  output logic [2:0]       state,
  output logic             busy,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_LW   = 7'h03;
  localparam logic [6:0] OPC_SW   = 7'h23;
  localparam logic [6:0] OPC_BEQ  = 7'h63;
  localparam logic [6:0] OPC_JAL  = 7'h6F;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [2:0]       state_q, state_d;
  logic [6:0]       opc_q;
  logic [2:0]       f3_q;
  logic             f7_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q;
  logic             decode_ok;
  logic [2:0]       alu_op;
  logic             alu_src;
  logic             unused_ins_bits;

  assign unused_ins_bits = ^{ins[31], ins[29:15], ins[11:7]};

  // Legality is judged on the live word in DECODE, the same cycle it is latched.
  always_comb begin
    decode_ok = 1'b0;
    case (ins[6:0])
      OPC_R: begin
        case (ins[14:12])
          3'b000, 3'b110, 3'b111, 3'b010: decode_ok = 1'b1;
          default:                         decode_ok = 1'b0;
        endcase
      end
      OPC_ADDI, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL: decode_ok = 1'b1;
      default: decode_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_op  = ALU_ADD;
    alu_src = 1'b0;
    case (opc_q)
      OPC_R: begin
        case (f3_q)
          3'b000:  alu_op = f7_q ? ALU_SUB : ALU_ADD;
          3'b110:  alu_op = ALU_OR;
          3'b111:  alu_op = ALU_AND;
          3'b010:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end
      OPC_ADDI, OPC_LW, OPC_SW: alu_src = 1'b1;
      OPC_BEQ:                  alu_op  = ALU_SUB;
      default:                  alu_op  = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    PCSel     = 2'b00;
    RegWrite  = 1'b0;
    ALUSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    MemToReg  = 1'b0;
    op        = ALU_ADD;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (decode_ok) begin
          state_d = S_EXEC;
        end else begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end
      end
      S_EXEC: begin
        op     = alu_op;
        ALUSrc = alu_src;
        case (opc_q)
          OPC_R, OPC_ADDI: state_d = S_WB;
          OPC_LW, OPC_SW:  state_d = S_MEM;
          OPC_BEQ: begin
            PCWrite = 1'b1;
            PCSel   = {1'b0, zero};
          end
          OPC_JAL: begin
            PCWrite = 1'b1;
            PCSel   = 2'b10;
          end
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        op       = alu_op;
        ALUSrc   = alu_src;
        MemRead  = (opc_q == OPC_LW);
        MemWrite = (opc_q == OPC_SW);
        if (memAck) begin
          if (opc_q == OPC_LW) state_d = S_WB;
          else                 PCWrite = 1'b1;
        end
      end
      S_WB: begin
        op       = alu_op;
        ALUSrc   = alu_src;
        RegWrite = 1'b1;
        MemToReg = (opc_q == OPC_LW);
        PCWrite  = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d   = S_HALT;
        illegal_d = 1'b1;
      end
    endcase
    // Every retire cycle decides between stopping and fetching the next word.
    if (PCWrite) state_d = haltReq ? S_IDLE : S_FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opc_q     <= 7'd0;
      f3_q      <= 3'd0;
      f7_q      <= 1'b0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == S_DECODE) begin
        opc_q <= ins[6:0];
        f3_q  <= ins[14:12];
        f7_q  <= ins[30];
      end
      if (PCWrite) retired_q <= retired_q + CNT_ONE;
    end
  end

  assign state   = state_q;
  assign busy    = (state_q >= S_FETCH) && (state_q <= S_WB);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for multicycle_ctrl; a narrow counter keeps
// the wrap scenario short.
module tb_multicycle_ctrl;

  localparam int CW = 8;
  localparam int W  = 17 + CW;

  logic          clk, rst_n, start, haltReq, zero, memAck;
  logic [31:0]   ins;
  logic          PCWrite, IRWrite, RegWrite, ALUSrc, MemRead, MemWrite, MemToReg;
  logic [1:0]    PCSel;
  logic [2:0]    op, state;
  logic          busy, illegal;
  logic [CW-1:0] retired;

  int checks = 0;
  int errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [CW-1:0] exp_ret;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_ADDI = 32'h00508093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_BADR = 32'h002091B3;
  localparam logic [31:0] I_BADO = 32'h0000007F;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .haltReq(haltReq), .ins(ins),
    .zero(zero), .memAck(memAck), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .PCSel(PCSel), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .op(op), .state(state),
    .busy(busy), .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rec(input logic [2:0] st, input logic pcw, irw,
                                       input logic [1:0] ps, input logic rw, asrc, mr, mw, m2r,
                                       input logic [2:0] o, input logic ill, input logic [CW-1:0] r);
    logic bsy;
    bsy = (st >= 3'd1) && (st <= 3'd5);
    return {st, pcw, irw, ps, rw, asrc, mr, mw, m2r, o, bsy, ill, r};
  endfunction

  function automatic logic [W-1:0] obs();
    return {state, PCWrite, IRWrite, PCSel, RegWrite, ALUSrc, MemRead, MemWrite,
            MemToReg, op, busy, illegal, retired};
  endfunction

  task automatic check_vec(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic expect_cycle(input string tag, input logic [W-1:0] e);
    logic [W-1:0] want;
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    check_vec(tag, obs(), want);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_idle(input string tag);
    expect_cycle(tag, rec(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
  endtask

  task automatic expect_halt(input string tag);
    expect_cycle(tag, rec(3'd6, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 1, exp_ret));
  endtask

  // Runs one instruction starting in FETCH; leaves the DUT in FETCH, IDLE or HALT.
  task automatic run_instr(input logic [31:0] iw, input logic z, input int waits,
                           input logic h, input logic noise);
    logic [6:0] opc;
    logic [2:0] alu;
    logic       asrc, ill, is_lw;
    opc = iw[6:0];
    ill = 1'b0; asrc = 1'b0; alu = 3'b010;
    case (opc)
      7'h33: begin
        case (iw[14:12])
          3'b000:  alu = iw[30] ? 3'b110 : 3'b010;
          3'b110:  alu = 3'b001;
          3'b111:  alu = 3'b000;
          3'b010:  alu = 3'b011;
          default: ill = 1'b1;
        endcase
      end
      7'h13, 7'h03, 7'h23: asrc = 1'b1;
      7'h63: alu = 3'b110;
      7'h6F: alu = 3'b010;
      default: ill = 1'b1;
    endcase
    is_lw = (opc == 7'h03);
    ins = iw; zero = z; haltReq = h; memAck = noise;
    expect_cycle("fetch", rec(3'd1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    expect_cycle("decode", rec(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    ins = $urandom();
    if (ill) begin
      expect_halt("illegal_halt");
      return;
    end
    case (opc)
      7'h33, 7'h13: begin
        expect_cycle("exec_alu", rec(3'd3, 0, 0, 2'b00, 0, asrc, 0, 0, 0, alu, 0, exp_ret));
        expect_cycle("wb_alu", rec(3'd5, 1, 0, 2'b00, 1, asrc, 0, 0, 0, alu, 0, exp_ret));
      end
      7'h03, 7'h23: begin
        expect_cycle("exec_mem", rec(3'd3, 0, 0, 2'b00, 0, 1, 0, 0, 0, 3'b010, 0, exp_ret));
        memAck = 1'b0;
        for (int i = 0; i < waits; i++)
          expect_cycle("mem_wait", rec(3'd4, 0, 0, 2'b00, 0, 1, is_lw, !is_lw, 0, 3'b010, 0, exp_ret));
        memAck = 1'b1;
        expect_cycle("mem_ack", rec(3'd4, !is_lw, 0, 2'b00, 0, 1, is_lw, !is_lw, 0, 3'b010, 0, exp_ret));
        memAck = noise;
        if (is_lw)
          expect_cycle("wb_lw", rec(3'd5, 1, 0, 2'b00, 1, 1, 0, 0, 1, 3'b010, 0, exp_ret));
      end
      7'h63: expect_cycle("exec_beq", rec(3'd3, 1, 0, {1'b0, z}, 0, 0, 0, 0, 0, 3'b110, 0, exp_ret));
      default: expect_cycle("exec_jal", rec(3'd3, 1, 0, 2'b10, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    endcase
    exp_ret++;
    haltReq = 1'b0;
    memAck  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_ret = '0;
    check_vec("reset_async", obs(), rec(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic launch();
    start = 1'b1;
    expect_idle("idle_start");
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; haltReq = 1'b0; zero = 1'b0; memAck = 1'b0; ins = '0;
    exp_ret = '0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_state", obs(), rec(3'd0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    rst_n = 1'b1;

    // IDLE ignores everything but start.
    haltReq = 1'b1; memAck = 1'b1;
    expect_idle("idle_hold0");
    expect_idle("idle_hold1");
    haltReq = 1'b0; memAck = 1'b0;
    launch();

    run_instr(I_ADD,  0, 0, 0, 0);
    run_instr(I_LW,   0, 3, 0, 0);
    run_instr(I_SW,   0, 2, 0, 1);
    run_instr(I_ADDI, 0, 0, 0, 1);
    run_instr(I_SUB,  0, 0, 0, 0);
    run_instr(I_OR,   0, 0, 0, 0);
    run_instr(I_AND,  0, 0, 0, 0);
    run_instr(I_SLT,  0, 0, 0, 0);
    run_instr(I_BEQ,  1, 0, 0, 0);
    run_instr(I_BEQ,  0, 0, 0, 1);
    run_instr(I_LW,   0, 0, 0, 0);
    run_instr(I_JAL,  0, 0, 1, 1);
    expect_idle("halt_req_idle");

    // Reset in the middle of a stalled store.
    launch();
    ins = I_SW; memAck = 1'b0;
    expect_cycle("sw_fetch", rec(3'd1, 0, 1, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    expect_cycle("sw_decode", rec(3'd2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 3'b010, 0, exp_ret));
    expect_cycle("sw_exec", rec(3'd3, 0, 0, 2'b00, 0, 1, 0, 0, 0, 3'b010, 0, exp_ret));
    expect_cycle("sw_mem", rec(3'd4, 0, 0, 2'b00, 0, 1, 0, 1, 0, 3'b010, 0, exp_ret));
    #2;
    check_vec("sw_mem_hold", obs(), rec(3'd4, 0, 0, 2'b00, 0, 1, 0, 1, 0, 3'b010, 0, exp_ret));
    do_reset();
    launch();
    run_instr(I_ADD, 0, 0, 1, 0);
    expect_idle("post_reset_idle");

    // Counter wrap with a halt request on the wrapping retire.
    do_reset();
    launch();
    for (int i = 0; i < (1 << CW) - 1; i++) run_instr(I_JAL, 0, 0, 0, i[0]);
    run_instr(I_JAL, 0, 0, 1, 0);
    expect_idle("wrap_idle");

    // Illegal R-type funct3, then an illegal opcode; HALT is sticky.
    launch();
    run_instr(I_BADR, 0, 0, 0, 0);
    start = 1'b1; memAck = 1'b1; haltReq = 1'b1;
    expect_halt("halt_sticky0");
    expect_halt("halt_sticky1");
    start = 1'b0; memAck = 1'b0; haltReq = 1'b0;
    do_reset();
    launch();
    run_instr(I_BADO, 0, 0, 0, 0);
    start = 1'b1; memAck = 1'b1;
    for (int i = 0; i < 3; i++) expect_halt("halt_sticky2");
    start = 1'b0; memAck = 1'b0;
    do_reset();
    expect_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
